// File: rtl/sb_pkg.sv
// Shared types and defaults for the store buffer.
// An entry holds the word index, the data and the store's instruction word.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_IDXW  = 10;

  typedef struct packed {
    logic [SB_IDXW-1:0] idx;
    logic [31:0]        data;
    logic [31:0]        ir;
  } sb_entry_t;

  // Data memory is 4 KiB, so only the word index within it is compared.
  function automatic logic [SB_IDXW-1:0] word_idx(input logic [31:0] addr);
    return addr[11:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-lookup and drain signals between the M stage and the store buffer.
// The master modport is the pipeline/memory side; the slave modport is the buffer.
interface store_buffer_if #(
  parameter int DEPTH = 4
);

  logic                     st_valid;
  logic [31:0]              st_addr;
  logic [31:0]              st_data;
  logic [31:0]              st_ir;
  logic                     st_ready;
  logic [31:0]              ld_addr;
  logic                     ld_hit;
  logic [31:0]              ld_data;
  logic                     drain_en;
  logic                     mem_wr;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wd;
  logic [31:0]              mem_ir;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;

  modport master (
    output st_valid, st_addr, st_data, st_ir, ld_addr, drain_en,
    input  st_ready, ld_hit, ld_data, mem_wr, mem_addr, mem_wd, mem_ir, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_ir, ld_addr, drain_en,
    output st_ready, ld_hit, ld_data, mem_wr, mem_addr, mem_wd, mem_ir, count, empty
  );

endinterface

// File: rtl/sb_match.sv
// Youngest-match selector: among valid entries whose index equals the lookup,
// returns the data of the one closest to (just behind) the tail pointer.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDXW  = SB_IDXW
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [IDXW-1:0]          idx_i  [DEPTH],
  input  logic [31:0]              data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] tail_i,
  input  logic [IDXW-1:0]          lookup_i,
  output logic                     hit_o,
  output logic [31:0]              data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] slot;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches overwrite earlier ones.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hit_o  = 1'b0;
    data_o = '0;
    slot   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      slot = tail_i - PW'(k);
      if (valid_i[slot] && idx_i[slot] == lookup_i) begin
        hit_o  = 1'b1;
        data_o = data_i[slot];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order word store queue between the M stage and data memory: one push and
// one drain per cycle, with a youngest-match bypass for loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDXW  = SB_IDXW
) (
  input  logic          Clk,
  input  logic          Reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  sb_entry_t        ent_q [DEPTH];

  logic             st_ready;
  logic             empty;
  logic             push;
  logic             drain;
  sb_entry_t        head_ent;
  logic [IDXW-1:0]  idx_vec  [DEPTH];
  logic [31:0]      data_vec [DEPTH];

  // Ready looks only at the registered count, so a full buffer refuses a store
  // even in a cycle where it also drains.
  assign st_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.st_valid && st_ready;
  assign drain    = bus.drain_en && !empty;
  assign head_ent = ent_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (push) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    if (drain) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    count_d = count_q + CW'(push) - CW'(drain);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: entry storage has no reset; the valid bits and count alone decide what is live.
  always_ff @(posedge Clk) begin
    if (push) begin
      ent_q[tail_q] <= '{idx: word_idx(bus.st_addr), data: bus.st_data, ir: bus.st_ir};
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      idx_vec[i]  = ent_q[i].idx;
      data_vec[i] = ent_q[i].data;
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_match (
    .valid_i  (valid_q),
    .idx_i    (idx_vec),
    .data_i   (data_vec),
    .tail_i   (tail_q),
    .lookup_i (word_idx(bus.ld_addr)),
    .hit_o    (bus.ld_hit),
    .data_o   (bus.ld_data)
  );

  assign bus.st_ready = st_ready;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.mem_wr   = drain;
  assign bus.mem_addr = {{(30-IDXW){1'b0}}, head_ent.idx, 2'b00};
  assign bus.mem_wd   = head_ent.data;
  assign bus.mem_ir   = head_ent.ir;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stimulus queues expected memory writes, and a
// negedge monitor pops and compares each write the buffer presents.
module tb_store_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ir;
  } wr_t;

  logic Clk;
  logic Reset;

  store_buffer_if #(.DEPTH(4)) bus ();

  store_buffer #(.DEPTH(4), .IDXW(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a store and record the write it should eventually produce.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] ir);
    wr_t w;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_ir    = ir;
    w.addr = {20'b0, a[11:2], 2'b00};
    w.data = d;
    w.ir   = ir;
    exp_q.push_back(w);
  endtask

  // Scoreboard monitor: a write strobe at negedge means the memory takes it on the next edge.
  always @(negedge Clk) begin
    if (!Reset && bus.mem_wr === 1'b1) begin
      $display("*%h <= %h", bus.mem_addr, bus.mem_wd);
      $display("%h", bus.mem_ir);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.mem_wr), 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("drain_addr", bus.mem_addr, w.addr);
        check("drain_wd",   bus.mem_wd,   w.data);
        check("drain_ir",   bus.mem_ir,   w.ir);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_ir    = '0;
    bus.ld_addr  = '0;
    bus.drain_en = 1'b1;

    // Reset, then idle with drain enabled.
    #1;
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_mem_wr",   32'(bus.mem_wr),   32'd0);
    check("rst_st_ready", 32'(bus.st_ready), 32'd1);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("idle_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("idle_empty",  32'(bus.empty),  32'd1);

    // Single store, held until drain is enabled.
    bus.drain_en = 1'b0;
    push_store(32'h10, 32'hAAAA_0001, 32'hAC00_0010);
    tick();
    bus.st_valid = 1'b0;
    check("single_count",  32'(bus.count),  32'd1);
    check("single_no_wr",  32'(bus.mem_wr), 32'd0);
    bus.drain_en = 1'b1;
    #1;
    check("single_mem_wr", 32'(bus.mem_wr), 32'd1);
    check("single_addr",   bus.mem_addr,    32'h10);
    check("single_wd",     bus.mem_wd,      32'hAAAA_0001);
    tick();
    check("single_done_wr",    32'(bus.mem_wr), 32'd0);
    check("single_done_empty", 32'(bus.empty),  32'd1);

    // Fill to DEPTH, reject a fifth store, then drain in order.
    bus.drain_en = 1'b0;
    push_store(32'h0, 32'h1111_0000, 32'hAC00_0000);
    tick();
    push_store(32'h4, 32'h1111_0004, 32'hAC00_0004);
    tick();
    push_store(32'h8, 32'h1111_0008, 32'hAC00_0008);
    tick();
    push_store(32'hC, 32'h1111_000C, 32'hAC00_000C);
    tick();
    bus.st_valid = 1'b0;
    check("full_count",    32'(bus.count),    32'd4);
    check("full_st_ready", 32'(bus.st_ready), 32'd0);
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h30;
    bus.st_data  = 32'hDEAD_BEEF;
    bus.st_ir    = 32'hAC00_0030;
    tick();
    bus.st_valid = 1'b0;
    check("drop_count", 32'(bus.count), 32'd4);
    bus.drain_en = 1'b1;
    repeat (4) tick();
    check("fill_drained_empty", 32'(bus.empty), 32'd1);

    // Youngest-match bypass with duplicate addresses.
    bus.drain_en = 1'b0;
    push_store(32'h20, 32'd1, 32'hAC00_0020);
    tick();
    push_store(32'h20, 32'd2, 32'hAC00_0021);
    tick();
    push_store(32'h28, 32'd3, 32'hAC00_0028);
    bus.ld_addr = 32'h28;
    #1;
    check("same_cycle_no_hit", 32'(bus.ld_hit), 32'd0);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_addr  = 32'h20;
    #1;
    check("ld_hit_dup",  32'(bus.ld_hit), 32'd1);
    check("ld_data_dup", bus.ld_data,     32'd2);
    bus.ld_addr = 32'h24;
    #1;
    check("ld_miss_hit",  32'(bus.ld_hit), 32'd0);
    check("ld_miss_data", bus.ld_data,     32'd0);
    bus.ld_addr = 32'h1020;
    #1;
    check("ld_upper_hit",  32'(bus.ld_hit), 32'd1);
    check("ld_upper_data", bus.ld_data,     32'd2);
    bus.ld_addr = 32'h28;
    #1;
    check("ld_third_data", bus.ld_data, 32'd3);

    // Asynchronous reset with three entries queued and a drain pending.
    bus.ld_addr  = 32'h20;
    bus.drain_en = 1'b1;
    #1;
    check("pre_rst_mem_wr", 32'(bus.mem_wr), 32'd1);
    Reset = 1'b1;
    #1;
    check("async_mem_wr",   32'(bus.mem_wr),   32'd0);
    check("async_ld_hit",   32'(bus.ld_hit),   32'd0);
    check("async_ld_data",  bus.ld_data,       32'd0);
    check("async_empty",    32'(bus.empty),    32'd1);
    check("async_st_ready", 32'(bus.st_ready), 32'd1);
    check("async_count",    32'(bus.count),    32'd0);
    exp_q.delete();
    tick();
    Reset = 1'b0;
    tick();

    // Full buffer: push and drain in the same cycle, push must be refused.
    bus.drain_en = 1'b0;
    push_store(32'h40, 32'h4000_0000, 32'hAC00_0040);
    tick();
    push_store(32'h44, 32'h4400_0000, 32'hAC00_0044);
    tick();
    push_store(32'h48, 32'h4800_0000, 32'hAC00_0048);
    tick();
    push_store(32'h4C, 32'h4C00_0000, 32'hAC00_004C);
    tick();
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h50;
    bus.st_data  = 32'h5000_0000;
    bus.st_ir    = 32'hAC00_0050;
    bus.drain_en = 1'b1;
    #1;
    check("full_drain_ready", 32'(bus.st_ready), 32'd0);
    check("full_drain_wr",    32'(bus.mem_wr),   32'd1);
    tick();
    check("full_drain_count", 32'(bus.count),    32'd3);
    check("retry_ready",      32'(bus.st_ready), 32'd1);
    push_store(32'h50, 32'h5000_0000, 32'hAC00_0050);
    tick();
    bus.st_valid = 1'b0;
    check("retry_count", 32'(bus.count), 32'd3);
    repeat (3) tick();
    check("retry_drained_empty", 32'(bus.empty), 32'd1);

    // Nine back-to-back push/drain pairs: pointers wrap, occupancy stays at one.
    for (int i = 0; i < 9; i++) begin
      push_store(32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 32'hAC01_0000 + 32'(i));
      tick();
      check("stream_count", 32'(bus.count), 32'd1);
    end
    bus.st_valid = 1'b0;
    tick();
    check("stream_end_count", 32'(bus.count), 32'd0);
    check("stream_end_empty", 32'(bus.empty), 32'd1);

    repeat (2) tick();
    check("exp_remaining", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
